pixel_buffer_drain: RTL

// - Consumer end of the shader->pixel-buffer interface: accepts pixel_buffer_entry_t writes (pb_we/pb_full).
// - Buffers the entries and drains them to the frame-buffer memory write port using a req/ack handshake.
// - Counts the pixels written and pulses frame_done once a full frame has been stored.
// - Sits between the shader and the frame-buffer SRAM controller.

---
 rtl/pixel_buffer_drain.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pixel_buffer_drain.sv
// Pixel-buffer consumer: queues shader entries in a small FIFO and drains them to the
// frame-buffer write port with req/ack, counting pixels per frame. Optional macro: PB_DOUBLE_BUFFER_EN.
module pixel_buffer_drain #(
    parameter int DEPTH        = 8,
    parameter int NUM_PIXELS   = 307200,
    parameter int ADDR_W       = 20,
    parameter int FRAME_STRIDE = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_we,
    input  logic [42:0]       pb_data_in,
    output logic              pb_full,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              frame_done,
    output logic [ADDR_W-1:0] display_base,
    output logic              overflow
);
    localparam int ID_W    = 19;
    localparam int COLOR_W = 24;
    localparam int ENTRY_W = COLOR_W + ID_W;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(NUM_PIXELS - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t               state_reg, state_next;
    logic [ENTRY_W-1:0]   buf_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]       count_reg, count_next;
    logic                 full_reg;
    logic                 overflow_reg;
    logic                 frame_done_reg;
    logic [CNT_W-1:0]     pixel_cnt_reg;
    logic [ADDR_W-1:0]    frame_base;
    logic [ENTRY_W-1:0]   head;
    logic                 push, pop, frame_wrap;

    // pb_full is the registered flag, so a push while full is dropped even if a pop happens
    assign push       = pb_we && !full_reg;
    assign pop        = (state_reg == WRITE) && mem_ack && (count_reg != '0);
    assign frame_wrap = pop && (pixel_cnt_reg == LAST_PIXEL);
    assign head       = buf_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset so it maps onto plain RAM; only the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_reg] <= pb_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            pixel_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
            if (pb_we && full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                pixel_cnt_reg <= frame_wrap ? '0 : pixel_cnt_reg + 1'b1;
            end
            frame_done_reg <= frame_wrap;
        end
    end

`ifdef PB_DOUBLE_BUFFER_EN
    logic [ADDR_W-1:0] frame_base_reg;
    logic [ADDR_W-1:0] display_base_reg;

    // Each completed frame flips writing to the other buffer and publishes the finished one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_base_reg   <= '0;
            display_base_reg <= '0;
        end else if (frame_wrap) begin
            display_base_reg <= frame_base_reg;
            frame_base_reg   <= (frame_base_reg == '0) ? ADDR_W'(FRAME_STRIDE) : '0;
        end
    end

    assign frame_base   = frame_base_reg;
    assign display_base = display_base_reg;
`else
    assign frame_base   = '0;
    assign display_base = '0;
`endif

    // Drain FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0) state_next = WRITE;
            WRITE:   if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM: outputs; address/data are forced to 0 outside WRITE so reset clears them too
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == WRITE) begin
            mem_req   = 1'b1;
            mem_addr  = frame_base + ADDR_W'(head[ID_W-1:0]);
            mem_wdata = head[ENTRY_W-1:ID_W];
        end
    end

    assign pb_full    = full_reg;
    assign overflow   = overflow_reg;
    assign frame_done = frame_done_reg;

endmodule
